channelizer_reload_sequencer: RTL and testbench
===============================================

Name: channelizer_reload_sequencer

Overview:
Control block between the axi_wrapper output stream and the channelizer input stream. It decodes user settings-bus writes and buffers filter coefficients written over the settings bus. On a reconfiguration request it closes the input stream at a packet boundary, waits for the channelizer output to go idle, streams the buffered coefficients into the channelizer reload port, issues a config-commit pulse and reopens the stream. It also provides a status readback word.

Parameters:
SR_BASE, 129, first settings address used. Addresses are SR_BASE+0 CTRL, +1 NUM_TAPS, +2 COEF.
COEF_W, 16, coefficient width; COEF writes use set_data[COEF_W-1:0].
TAP_W, 11, width of the tap count and FIFO level.
FIFO_DEPTH, 1024, coefficient buffer depth (power of two, ≤ 2^TAP_W).
DRAIN_CYCLES, 64, number of consecutive idle output cycles that count as drained.
TIMEOUT, 65535, STOP watchdog limit (used only with the optional feature).

Ports:
ce_clk  in  1  clock
ce_rst_n  in  1  synchronous reset, active-low
set_stb  in  1  settings strobe
set_addr  in  8  settings address
set_data  in  32  settings data
s_tdata  in  32  sample stream from the wrapper
s_tlast  in  1  last beat of the input packet
s_tvalid  in  1  input valid
s_tready  out  1  input ready
m_tdata  out  32  sample stream to the channelizer
m_tlast  out  1  last beat to the channelizer
m_tvalid  out  1  valid to the channelizer
m_tready  in  1  channelizer ready
mon_tvalid  in  1  channelizer output valid (monitor only)
mon_tready  in  1  channelizer output ready (monitor only)
reload_tdata  out  COEF_W  coefficient to the channelizer
reload_tvalid  out  1  coefficient valid
reload_tlast  out  1  asserted on coefficient NUM_TAPS-1
reload_tready  in  1  reload ready
cfg_commit  out  1  one-cycle coefficient commit pulse
rb_data  out  64  status readback

Behaviour:
- Reset (ce_rst_n low at an ce_clk edge):
  - State goes to IDLE; FIFO is emptied; NUM_TAPS=0; CTRL=0; sticky flags cleared.
  - Outputs: s_tready=0, m_tvalid=0, reload_tvalid=0, reload_tlast=0, cfg_commit=0, rb_data=0.
  - Reset is allowed mid-packet or mid-load; no completion is attempted.
- CTRL register bits:
  - bit0 ENABLE (level).
  - bit1 RELOAD_REQ (self-clearing; it is a pulse).
  - bit2 CLR_FLAGS (self-clearing).
- Gate: m_tdata=s_tdata and m_tlast=s_tlast always. m_tvalid = s_tvalid & pass; s_tready = m_tready & pass. The gate adds zero latency.
- pass=1 in RUN and STOP only. The gate closes only on the cycle after a tlast handshake, so no beat is ever split.
- FSM transitions:
  - IDLE: pass=0. ENABLE=1 and no pending request -> RUN. A pending request -> LOAD, since the stream is already quiet.
  - RUN: RELOAD_REQ or ENABLE=0 -> STOP. The request is latched as pending.
  - STOP: wait for an s_tvalid & s_tready & s_tlast handshake, then -> DRAIN. If no beat is in progress (s_tvalid=0), wait anyway; a boundary means tlast.
  - DRAIN: an idle counter increments on each cycle where mon_tvalid is 0, and resets to 0 on mon_tvalid. When the count reaches DRAIN_CYCLES: go to LOAD if pending, else IDLE.
  - LOAD: reload_tvalid = FIFO not empty. Each reload handshake pops one word and increments the tap counter. reload_tlast = (count == NUM_TAPS-1). After the handshake of the tlast beat -> ARM. If the FIFO empties early, stall and wait for more COEF writes. NUM_TAPS=0: go to ARM immediately with no beats.
  - ARM: cfg_commit=1 for one cycle; clear pending; then -> RUN if ENABLE, else IDLE.
- COEF writes push into the FIFO in any state. A write to a full FIFO is dropped and sets the sticky OVF flag. A pop and a push in the same cycle are both accepted, and the level is unchanged.
- NUM_TAPS writes are accepted in any state except LOAD. A NUM_TAPS write during LOAD is ignored and sets the sticky BUSY flag.
- RELOAD_REQ while a request is already pending, or in DRAIN, LOAD or ARM: ignored, and sets BUSY.
- Readback: rb_data = {32'd0, 5'd0, TMO, OVF, BUSY, level[TAP_W-1:0] zero-extended to 16, 5'd0, state[2:0]}. It is registered, so it lags by 1 cycle.
- State encoding: IDLE=0, RUN=1, STOP=2, DRAIN=3, LOAD=4, ARM=5.

Optional Feature:
CHAN_RELOAD_TIMEOUT_EN
- Defined: STOP runs a watchdog. After TIMEOUT cycles without a tlast handshake, the FSM forces -> DRAIN, sets the sticky TMO flag and closes the gate; any partial packet is abandoned.
- Undefined: STOP waits indefinitely, TMO always reads 0, and no counter is synthesised.

Decomposition:
- Package channelizer_pkg:
  - state enum;
  - register offsets (CTRL=0, NUM_TAPS=1, COEF=2);
  - CTRL bit indices;
  - rb_data field positions.
- Sub-module channelizer_coef_fifo: synchronous single-clock FIFO of FIFO_DEPTH×COEF_W, with full, empty and level outputs and the same active-low synchronous reset.

Test Plan:
1. Reset, then ENABLE=1 with a 16-beat packet -> all beats pass with zero latency; rb_data[2:0]=1; cfg_commit is never asserted.
2. NUM_TAPS=8, eight COEF writes 0x0001..0x0008, RELOAD_REQ in the middle of the 4th beat of a 16-beat packet -> all 16 beats complete, then s_tready=0. After 64 idle mon cycles, reload carries 1..8 with reload_tlast on 0x0008; cfg_commit pulses once; the stream reopens.
3. RELOAD_REQ with NUM_TAPS=4 and only 2 coefficients buffered -> LOAD stalls after 2 beats; writing 2 more coefficients completes the load, and tlast falls on the 4th beat.
4. 1025 COEF writes with FIFO_DEPTH=1024 -> level=1024, OVF=1; CLR_FLAGS -> OVF=0.
5. Second RELOAD_REQ and a NUM_TAPS write during LOAD -> BUSY=1; NUM_TAPS is unchanged; only one cfg_commit occurs.
6. ce_rst_n low during LOAD -> next cycle reload_tvalid=0, level=0, state=IDLE. With CHAN_RELOAD_TIMEOUT_EN and TIMEOUT=100, a packet that never sends tlast -> TMO=1 at cycle 100 of STOP.

Source files
------------

// File: rtl/channelizer_reload_sequencer_pkg.sv
// Shared types and constants for the channelizer reload sequencer: FSM states,
// settings-register offsets, CTRL bit indices and readback field positions.
package channelizer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STOP  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_LOAD  = 3'd4,
    ST_ARM   = 3'd5
  } state_t;

  localparam int REG_CTRL     = 0;
  localparam int REG_NUM_TAPS = 1;
  localparam int REG_COEF     = 2;

  localparam int CTRL_ENABLE     = 0;
  localparam int CTRL_RELOAD_REQ = 1;
  localparam int CTRL_CLR_FLAGS  = 2;

  localparam int RB_STATE_LSB = 0;
  localparam int RB_LEVEL_LSB = 8;
  localparam int RB_BUSY      = 24;
  localparam int RB_OVF       = 25;
  localparam int RB_TMO       = 26;

  function automatic logic [7:0] reg_addr(input int base, input int off);
    return 8'(base + off);
  endfunction

endpackage

// File: rtl/channelizer_reload_sequencer_if.sv
// Bundle of settings bus, sample streams, monitor, reload stream and status
// signals; the sequencer takes the slave view, its environment the master view.
interface channelizer_reload_sequencer_if #(
  parameter int COEF_W = 16
);
  logic              set_stb;
  logic [7:0]        set_addr;
  logic [31:0]       set_data;
  logic [31:0]       s_tdata;
  logic              s_tlast;
  logic              s_tvalid;
  logic              s_tready;
  logic [31:0]       m_tdata;
  logic              m_tlast;
  logic              m_tvalid;
  logic              m_tready;
  logic              mon_tvalid;
  logic              mon_tready;
  logic [COEF_W-1:0] reload_tdata;
  logic              reload_tvalid;
  logic              reload_tlast;
  logic              reload_tready;
  logic              cfg_commit;
  logic [63:0]       rb_data;

  modport slave (
    input  set_stb, set_addr, set_data,
    input  s_tdata, s_tlast, s_tvalid,
    output s_tready,
    output m_tdata, m_tlast, m_tvalid,
    input  m_tready,
    input  mon_tvalid, mon_tready,
    output reload_tdata, reload_tvalid, reload_tlast,
    input  reload_tready,
    output cfg_commit, rb_data
  );

  modport master (
    output set_stb, set_addr, set_data,
    output s_tdata, s_tlast, s_tvalid,
    input  s_tready,
    input  m_tdata, m_tlast, m_tvalid,
    output m_tready,
    output mon_tvalid, mon_tready,
    input  reload_tdata, reload_tvalid, reload_tlast,
    output reload_tready,
    input  cfg_commit, rb_data
  );
endinterface

// File: rtl/channelizer_coef_fifo.sv
// Single-clock coefficient FIFO on an inferred RAM with registered read; the
// read address is looked ahead so o_rdata always presents the current head.
module channelizer_coef_fifo #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 16,
  parameter int LVL_W = 11
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [LVL_W-1:0] o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic [WIDTH-1:0] r_rdata;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic [AW-1:0]    w_rd_addr;

  assign o_full    = (r_level == (AW+1)'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = LVL_W'(r_level);
  assign o_rdata   = r_rdata;
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_rd_addr = w_pop_ok ? AW'(r_rd_ptr + 1'b1) : r_rd_ptr;

  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Forward the write when it lands on the entry that becomes the head.
  always_ff @(posedge i_clk) begin
    if (w_push_ok && (r_wr_ptr == w_rd_addr)) begin
      r_rdata <= i_wdata;
    end else begin
      r_rdata <= r_mem[w_rd_addr];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= AW'(r_wr_ptr + 1'b1);
      end
      r_rd_ptr <= w_rd_addr;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/channelizer_reload_sequencer.sv
// Closes the sample stream at a packet boundary, drains the channelizer, reloads
// buffered coefficients and commits them. Optional STOP watchdog: CHAN_RELOAD_TIMEOUT_EN.
module channelizer_reload_sequencer
  import channelizer_pkg::*;
#(
  parameter int SR_BASE      = 129,
  parameter int COEF_W       = 16,
  parameter int TAP_W        = 11,
  parameter int FIFO_DEPTH   = 1024,
  parameter int DRAIN_CYCLES = 64,
  parameter int TIMEOUT      = 65535
) (
  input logic                            ce_clk,
  input logic                            ce_rst_n,
  channelizer_reload_sequencer_if.slave  bus
);
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  state_t             r_state;
  state_t             w_state_next;
  logic               r_enable;
  logic               r_pending;
  logic               r_busy;
  logic               r_ovf;
  logic [TAP_W-1:0]   r_num_taps;
  logic [TAP_W-1:0]   r_tap_cnt;
  logic [DRAIN_W-1:0] r_idle_cnt;
  logic [63:0]        r_rb;
  logic [63:0]        w_rb;

  logic               w_wr_ctrl;
  logic               w_wr_taps;
  logic               w_wr_coef;
  logic               w_req;
  logic               w_clr;
  logic               w_req_busy;
  logic               w_req_accept;
  logic               w_taps_busy;
  logic               w_pass;
  logic               w_in_last_hs;
  logic               w_taps_zero;
  logic               w_reload_valid;
  logic               w_reload_last;
  logic               w_reload_hs;
  logic               w_drained;
  logic               w_tmo_fire;
  logic               w_tmo;
  logic [COEF_W-1:0]  w_fifo_rdata;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [TAP_W-1:0]   w_level;

  assign w_wr_ctrl    = bus.set_stb && (bus.set_addr == reg_addr(SR_BASE, REG_CTRL));
  assign w_wr_taps    = bus.set_stb && (bus.set_addr == reg_addr(SR_BASE, REG_NUM_TAPS));
  assign w_wr_coef    = bus.set_stb && (bus.set_addr == reg_addr(SR_BASE, REG_COEF));
  assign w_req        = w_wr_ctrl & bus.set_data[CTRL_RELOAD_REQ];
  assign w_clr        = w_wr_ctrl & bus.set_data[CTRL_CLR_FLAGS];
  assign w_req_busy   = w_req & (r_pending | (r_state inside {ST_DRAIN, ST_LOAD, ST_ARM}));
  assign w_req_accept = w_req & ~w_req_busy;
  assign w_taps_busy  = w_wr_taps & (r_state == ST_LOAD);

  // Zero-latency gate: only valid/ready are qualified, data passes straight through.
  assign w_pass       = (r_state == ST_RUN) || (r_state == ST_STOP);
  assign bus.m_tdata  = bus.s_tdata;
  assign bus.m_tlast  = bus.s_tlast;
  assign bus.m_tvalid = bus.s_tvalid & w_pass;
  assign bus.s_tready = bus.m_tready & w_pass;
  assign w_in_last_hs = bus.s_tvalid & bus.m_tready & w_pass & bus.s_tlast;

  assign w_taps_zero    = (r_num_taps == '0);
  assign w_reload_valid = (r_state == ST_LOAD) & ~w_fifo_empty & ~w_taps_zero;
  assign w_reload_last  = (r_state == ST_LOAD) & ~w_taps_zero &
                          (r_tap_cnt == TAP_W'(r_num_taps - 1'b1));
  assign w_reload_hs    = w_reload_valid & bus.reload_tready;
  assign w_drained      = (r_idle_cnt == DRAIN_W'(DRAIN_CYCLES));

  assign bus.reload_tdata  = w_fifo_rdata;
  assign bus.reload_tvalid = w_reload_valid;
  assign bus.reload_tlast  = w_reload_last;
  assign bus.cfg_commit    = (r_state == ST_ARM);
  assign bus.rb_data       = r_rb;

  channelizer_coef_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (COEF_W),
    .LVL_W (TAP_W)
  ) u_coef_fifo (
    .i_clk   (ce_clk),
    .i_rst_n (ce_rst_n),
    .i_push  (w_wr_coef),
    .i_wdata (bus.set_data[COEF_W-1:0]),
    .i_pop   (w_reload_hs),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (w_level)
  );

`ifdef CHAN_RELOAD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_tmo;

  always_ff @(posedge ce_clk) begin
    if (!ce_rst_n || (r_state != ST_STOP)) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge ce_clk) begin
    if (!ce_rst_n) begin
      r_tmo <= 1'b0;
    end else begin
      r_tmo <= (r_tmo & ~w_clr) | w_tmo_fire;
    end
  end

  assign w_tmo_fire = (r_state == ST_STOP) && !w_in_last_hs &&
                      (r_tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign w_tmo      = r_tmo;
`else
  assign w_tmo_fire = 1'b0;
  assign w_tmo      = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (r_pending) w_state_next = ST_LOAD;
                else if (r_enable) w_state_next = ST_RUN;
      ST_RUN:   if (w_req_accept || r_pending || !r_enable) w_state_next = ST_STOP;
      ST_STOP:  if (w_in_last_hs || w_tmo_fire) w_state_next = ST_DRAIN;
      ST_DRAIN: if (w_drained) w_state_next = r_pending ? ST_LOAD : ST_IDLE;
      ST_LOAD:  if (w_taps_zero || (w_reload_hs && w_reload_last)) w_state_next = ST_ARM;
      ST_ARM:   w_state_next = r_enable ? ST_RUN : ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge ce_clk) begin
    if (!ce_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge ce_clk) begin
    if (!ce_rst_n) begin
      r_enable   <= 1'b0;
      r_pending  <= 1'b0;
      r_num_taps <= '0;
      r_busy     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_enable <= bus.set_data[CTRL_ENABLE];
      if (r_state == ST_ARM) r_pending <= 1'b0;
      else if (w_req_accept) r_pending <= 1'b1;
      if (w_wr_taps && !w_taps_busy) r_num_taps <= bus.set_data[TAP_W-1:0];
      // A new event in the same cycle as CLR_FLAGS still latches.
      r_busy <= (r_busy & ~w_clr) | w_req_busy | w_taps_busy;
      r_ovf  <= (r_ovf & ~w_clr) | (w_wr_coef & w_fifo_full);
    end
  end

  always_ff @(posedge ce_clk) begin
    if (!ce_rst_n || (r_state != ST_DRAIN) || bus.mon_tvalid) begin
      r_idle_cnt <= '0;
    end else if (!w_drained) begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge ce_clk) begin
    if (!ce_rst_n || (r_state != ST_LOAD)) begin
      r_tap_cnt <= '0;
    end else if (w_reload_hs) begin
      r_tap_cnt <= r_tap_cnt + 1'b1;
    end
  end

  always_comb begin
    w_rb = '0;
    w_rb[RB_STATE_LSB +: 3]  = r_state;
    w_rb[RB_LEVEL_LSB +: 16] = 16'(w_level);
    w_rb[RB_BUSY]            = r_busy;
    w_rb[RB_OVF]             = r_ovf;
    w_rb[RB_TMO]             = w_tmo;
  end

  always_ff @(posedge ce_clk) begin
    if (!ce_rst_n) begin
      r_rb <= '0;
    end else begin
      r_rb <= w_rb;
    end
  end

endmodule

// File: tb/tb_channelizer_reload_sequencer.sv
// Directed bench for the reload sequencer: pass-through gate, drain, reload,
// stall, overflow, busy, reset during load and the STOP watchdog.
module tb_channelizer_reload_sequencer;
  localparam int SR_BASE = 129;

  logic ce_clk = 1'b0;
  logic ce_rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  int   n_commit = 0;
  logic [16:0] rl_q [$];

  channelizer_reload_sequencer_if #(.COEF_W(16)) bus ();

  channelizer_reload_sequencer #(
    .SR_BASE (SR_BASE), .COEF_W (16), .TAP_W (11), .FIFO_DEPTH (1024),
    .DRAIN_CYCLES (64), .TIMEOUT (100)
  ) dut (
    .ce_clk   (ce_clk),
    .ce_rst_n (ce_rst_n),
    .bus      (bus)
  );

  always #5 ce_clk = ~ce_clk;

  always @(negedge ce_clk) begin
    if (ce_rst_n && bus.cfg_commit) n_commit++;
    if (ce_rst_n && bus.reload_tvalid && bus.reload_tready)
      rl_q.push_back({bus.reload_tlast, bus.reload_tdata});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge ce_clk); #1;
    end
  endtask

  task automatic wr(input int off, input logic [31:0] data);
    bus.set_stb = 1'b1; bus.set_addr = 8'(SR_BASE + off); bus.set_data = data;
    tick();
    bus.set_stb = 1'b0;
  endtask

  // Sends an n-beat packet; optionally issues ENABLE|RELOAD_REQ alongside beat req_beat.
  task automatic send_pkt(input int n, input logic [31:0] base, input int req_beat,
                          output int n_hs, output bit ok);
    bit hs;
    n_hs = 0; ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.s_tvalid = 1'b1; bus.s_tdata = base + 32'(i); bus.s_tlast = (i == n - 1);
      if (i == req_beat) begin
        bus.set_stb = 1'b1; bus.set_addr = 8'(SR_BASE); bus.set_data = 32'd3;
      end
      hs = 1'b0;
      for (int c = 0; c < 50 && !hs; c++) begin
        @(negedge ce_clk);
        if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== bus.s_tdata || bus.m_tlast !== bus.s_tlast)
          ok = 1'b0;
        hs = (bus.s_tready === 1'b1);
        @(posedge ce_clk); #1;
        bus.set_stb = 1'b0;
      end
      if (hs) n_hs++;
    end
    bus.s_tvalid = 1'b0; bus.s_tlast = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st);
    for (int c = 0; c < 300 && bus.rb_data[2:0] !== st; c++) tick();
    chk(tag, 64'(bus.rb_data[2:0]), 64'(st));
  endtask

  task automatic wait_commit(input string tag, input int target);
    for (int c = 0; c < 500 && n_commit < target; c++) tick();
    chk(tag, 64'(n_commit), 64'(target));
  endtask

  task automatic check_reload(input string tag, input int first, input int n);
    bit ok;
    chk({tag, "_count"}, 64'(rl_q.size()), 64'(n));
    ok = (rl_q.size() == n);
    for (int i = 0; i < n && ok; i++)
      if (rl_q[i] !== {(i == n - 1), 16'(first + i)}) ok = 1'b0;
    chk({tag, "_beats"}, 64'(ok), 64'd1);
  endtask

  initial begin
    int  n_hs;
    bit  ok;
    bus.set_stb = 1'b0; bus.set_addr = '0; bus.set_data = '0;
    bus.s_tdata = '0; bus.s_tlast = 1'b0; bus.s_tvalid = 1'b1;
    bus.m_tready = 1'b1; bus.mon_tvalid = 1'b0; bus.mon_tready = 1'b1;
    bus.reload_tready = 1'b1;

    // Reset with live upstream valid and downstream ready
    tick(3);
    chk("rst_s_tready", 64'(bus.s_tready), 64'd0);
    chk("rst_m_tvalid", 64'(bus.m_tvalid), 64'd0);
    chk("rst_reload_tvalid", 64'(bus.reload_tvalid), 64'd0);
    chk("rst_reload_tlast", 64'(bus.reload_tlast), 64'd0);
    chk("rst_cfg_commit", 64'(bus.cfg_commit), 64'd0);
    chk("rst_rb_data", bus.rb_data, 64'd0);
    bus.s_tvalid = 1'b0;
    ce_rst_n = 1'b1;
    tick();

    // 1: enable and pass a 16-beat packet
    wr(0, 32'd1);
    tick();
    send_pkt(16, 32'h100, -1, n_hs, ok);
    chk("t1_beats", 64'(n_hs), 64'd16);
    chk("t1_zero_latency", 64'(ok), 64'd1);
    tick();
    chk("t1_state_run", 64'(bus.rb_data[2:0]), 64'd1);
    chk("t1_no_commit", 64'(n_commit), 64'd0);

    // 2: eight taps, request during beat 4, drain with a busy monitor burst
    wr(1, 32'd8);
    for (int i = 1; i <= 8; i++) wr(2, 32'(i));
    tick();
    chk("t2_level", 64'(bus.rb_data[23:8]), 64'd8);
    send_pkt(16, 32'h200, 3, n_hs, ok);
    chk("t2_beats", 64'(n_hs), 64'd16);
    chk("t2_zero_latency", 64'(ok), 64'd1);
    chk("t2_gate_closed", 64'(bus.s_tready), 64'd0);
    bus.mon_tvalid = 1'b1;
    tick(10);
    bus.mon_tvalid = 1'b0;
    tick(60);
    chk("t2_still_draining", 64'(bus.rb_data[2:0]), 64'd3);
    chk("t2_no_early_reload", 64'(rl_q.size()), 64'd0);
    wait_commit("t2_commit", 1);
    check_reload("t2_reload", 1, 8);
    tick(2);
    chk("t2_reopen_state", 64'(bus.rb_data[2:0]), 64'd1);
    chk("t2_reopen_ready", 64'(bus.s_tready), 64'd1);

    // 3: load stalls on an empty buffer, then completes
    wr(1, 32'd4);
    wr(2, 32'h11);
    wr(2, 32'h12);
    rl_q.delete();
    wr(0, 32'd3);
    send_pkt(1, 32'h300, -1, n_hs, ok);
    chk("t3_stop_beat", 64'(n_hs), 64'd1);
    for (int c = 0; c < 200 && rl_q.size() < 2; c++) tick();
    tick(5);
    chk("t3_stalled_beats", 64'(rl_q.size()), 64'd2);
    chk("t3_stalled_state", 64'(bus.rb_data[2:0]), 64'd4);
    wr(2, 32'h13);
    wr(2, 32'h14);
    wait_commit("t3_commit", 2);
    check_reload("t3_reload", 32'h11, 4);

    // 4: overflow the 1024-deep buffer, then clear the flags
    bus.set_stb = 1'b1; bus.set_addr = 8'(SR_BASE + 2);
    for (int i = 0; i < 1025; i++) begin
      bus.set_data = 32'(i);
      tick();
    end
    bus.set_stb = 1'b0;
    tick(2);
    chk("t4_level_full", 64'(bus.rb_data[23:8]), 64'd1024);
    chk("t4_ovf_set", 64'(bus.rb_data[25]), 64'd1);
    wr(0, 32'd5);
    tick(2);
    chk("t4_ovf_cleared", 64'(bus.rb_data[25]), 64'd0);
    chk("t4_busy_clear", 64'(bus.rb_data[24]), 64'd0);

    // 5: second request and NUM_TAPS write while loading
    wr(1, 32'd3);
    bus.reload_tready = 1'b0;
    rl_q.delete();
    wr(0, 32'd3);
    send_pkt(1, 32'h500, -1, n_hs, ok);
    wait_state("t5_in_load", 3'd4);
    wr(1, 32'd7);
    wr(0, 32'd3);
    tick(2);
    chk("t5_busy_set", 64'(bus.rb_data[24]), 64'd1);
    bus.reload_tready = 1'b1;
    wait_commit("t5_commit", 3);
    check_reload("t5_reload", 0, 3);
    tick(100);
    chk("t5_single_commit", 64'(n_commit), 64'd3);

    // 6: reset in the middle of a load
    bus.reload_tready = 1'b0;
    wr(0, 32'd3);
    send_pkt(1, 32'h600, -1, n_hs, ok);
    wait_state("t6_in_load", 3'd4);
    chk("t6_reload_pending", 64'(bus.reload_tvalid), 64'd1);
    ce_rst_n = 1'b0;
    tick();
    chk("t6_reload_dropped", 64'(bus.reload_tvalid), 64'd0);
    ce_rst_n = 1'b1;
    tick(2);
    chk("t6_rb_idle_empty", bus.rb_data, 64'd0);

    // 7: request during a packet that never ends
    wr(0, 32'd1);
    tick();
    bus.s_tvalid = 1'b1; bus.s_tlast = 1'b0; bus.s_tdata = 32'h700;
    wr(0, 32'd3);
`ifdef CHAN_RELOAD_TIMEOUT_EN
    tick(98);
    chk("t7_pre_tmo", 64'(bus.rb_data[26:24]), 64'd0);
    chk("t7_pre_state", 64'(bus.rb_data[2:0]), 64'd2);
    tick(3);
    chk("t7_tmo_set", 64'(bus.rb_data[26]), 64'd1);
    chk("t7_tmo_drain", 64'(bus.rb_data[2:0]), 64'd3);
    chk("t7_gate_closed", 64'(bus.s_tready), 64'd0);
`else
    tick(150);
    chk("t7_tmo_zero", 64'(bus.rb_data[26]), 64'd0);
    chk("t7_stop_waits", 64'(bus.rb_data[2:0]), 64'd2);
    chk("t7_gate_open", 64'(bus.s_tready), 64'd1);
`endif
    bus.s_tvalid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
